// File: rtl/msp430_clock_pkg.sv
// Shared types and constants for the MSP430 clock-switch controller.
// The output decode lives here so the FSM and any future observers agree on it.
package msp430_clock_pkg;

  localparam int SYNC_STAGES  = 2;
  localparam int FORCE_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE0,
    WAIT_OSC,
    SW_TO1,
    SEL1,
    SW_TO0,
    FORCE
  } state_e;

  typedef struct packed {
    logic selection;
    logic mux_force_rst;
    logic sel_status;
    logic busy;
  } ctrl_out_t;

  // Moore decode of the per-state outputs.
  function automatic ctrl_out_t state_outputs(input state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      WAIT_OSC: o.busy = 1'b1;
      SW_TO1: begin
        o.selection = 1'b1;
        o.busy      = 1'b1;
      end
      SEL1: begin
        o.selection  = 1'b1;
        o.sel_status = 1'b1;
      end
      SW_TO0: o.busy = 1'b1;
      FORCE: begin
        o.mux_force_rst = 1'b1;
        o.busy          = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/msp430_sync_cell.sv
// N-stage synchroniser for a single asynchronous level into the local clock domain.
// Clears to 0 on the asynchronous active-high reset.
module msp430_sync_cell
  import msp430_clock_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // stage samples the value its predecessor held before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/msp430_clock_switch_ctrl.sv
// Initiator side of the glitch-free clock mux handshake: qualifies clk_in1, drives
// the mux selection, supervises clk_in1 while selected and falls back on failure.
module msp430_clock_switch_ctrl
  import msp430_clock_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int OSC_TIMEOUT = 200,
  parameter int ACK_TIMEOUT = 32,
  parameter int ACT_WINDOW  = 16
) (
  input  logic clk_in0_inv,
  input  logic reset,
  input  logic req_sel,
  input  logic osc1_ready,
  input  logic clk1_toggle,
  input  logic mux_ack,
  input  logic fail_clr,
  output logic selection,
  output logic mux_force_rst,
  output logic sel_status,
  output logic busy,
  output logic fail_irq,
  output logic fail_flag
);

  localparam logic [CNT_W-1:0] OSC_LIMIT  = CNT_W'(OSC_TIMEOUT);
  localparam logic [CNT_W-1:0] ACK_LIMIT  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ACT_LIMIT  = CNT_W'(ACT_WINDOW);
  localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(FORCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic osc1_ready_s;
  logic clk1_toggle_s;
  logic mux_ack_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       edge_cnt_q, edge_cnt_d;
  logic             tog_prev_q;
  logic             fail_flag_q, fail_flag_d;
  logic             fail_irq_q;
  logic             fail_ev;
  logic             toggle_edge;
  ctrl_out_t        out_q;

  msp430_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_osc (
    .clk_i (clk_in0_inv),
    .rst_i (reset),
    .d_i   (osc1_ready),
    .q_o   (osc1_ready_s)
  );

  msp430_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_tog (
    .clk_i (clk_in0_inv),
    .rst_i (reset),
    .d_i   (clk1_toggle),
    .q_o   (clk1_toggle_s)
  );

  msp430_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk_i (clk_in0_inv),
    .rst_i (reset),
    .d_i   (mux_ack),
    .q_o   (mux_ack_s)
  );

  assign toggle_edge = clk1_toggle_s ^ tog_prev_q;

  // Within each state a fail condition outranks mux_ack_s, which outranks req_sel.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    fail_ev = 1'b0;
    unique case (state_q)
      IDLE0: begin
        if (req_sel && !fail_flag_q) state_d = WAIT_OSC;
      end
      WAIT_OSC: begin
        if (cnt_q == OSC_LIMIT) begin
          fail_ev = 1'b1;
          state_d = IDLE0;
        end else if (!req_sel) begin
          state_d = IDLE0;
        end else if (osc1_ready_s && edge_cnt_q == 2'd2) begin
          state_d = SW_TO1;
        end
      end
      SW_TO1: begin
        if (cnt_q == ACK_LIMIT) begin
          fail_ev = 1'b1;
          state_d = SW_TO0;
        end else if (mux_ack_s) begin
          state_d = SEL1;
        end
      end
      SEL1: begin
        if (cnt_q == ACT_LIMIT || !osc1_ready_s) begin
          fail_ev = 1'b1;
          state_d = SW_TO0;
        end else if (!req_sel) begin
          state_d = SW_TO0;
        end
      end
      SW_TO0: begin
        if (cnt_q == ACK_LIMIT) begin
          state_d = FORCE;
        end else if (!mux_ack_s) begin
          state_d = IDLE0;
        end
      end
      FORCE: begin
        if (cnt_q == FORCE_LAST) state_d = IDLE0;
      end
      default: state_d = IDLE0;
    endcase
  end

  // Shared counter: per-state timeout, doubling as the activity window in SEL1.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == SEL1 && toggle_edge) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Only edges observed while waiting for the oscillator count as proof of life.
  always_comb begin
    if (state_d != state_q) begin
      edge_cnt_d = 2'd0;
    end else if (state_q == WAIT_OSC && toggle_edge && edge_cnt_q != 2'd2) begin
      edge_cnt_d = edge_cnt_q + 2'd1;
    end else begin
      edge_cnt_d = edge_cnt_q;
    end
  end

  // A new failure wins over a coincident clear.
  always_comb begin
    if (fail_ev) begin
      fail_flag_d = 1'b1;
    end else if (fail_clr) begin
      fail_flag_d = 1'b0;
    end else begin
      fail_flag_d = fail_flag_q;
    end
  end

  always_ff @(posedge clk_in0_inv or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE0;
      cnt_q       <= '0;
      edge_cnt_q  <= 2'd0;
      tog_prev_q  <= 1'b0;
      fail_flag_q <= 1'b0;
      fail_irq_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      tog_prev_q  <= clk1_toggle_s;
      fail_flag_q <= fail_flag_d;
      fail_irq_q  <= fail_ev;
      out_q       <= state_outputs(state_d);
    end
  end

  assign selection     = out_q.selection;
  assign mux_force_rst = out_q.mux_force_rst;
  assign sel_status    = out_q.sel_status;
  assign busy          = out_q.busy;
  assign fail_irq      = fail_irq_q;
  assign fail_flag     = fail_flag_q;

endmodule

// File: tb/tb_msp430_clock_switch_ctrl.sv
// Directed bench for msp430_clock_switch_ctrl: hand-computed cycle counts for the
// switch, fail, force and reset sequences.
module tb_msp430_clock_switch_ctrl;

  logic clk_in0_inv;
  logic reset;
  logic req_sel;
  logic osc1_ready;
  logic clk1_toggle;
  logic mux_ack;
  logic fail_clr;
  logic selection;
  logic mux_force_rst;
  logic sel_status;
  logic busy;
  logic fail_irq;
  logic fail_flag;

  bit tog_en;
  int n_cmp;
  int n_err;
  int irq_cnt;
  int irq_base;
  int first_force;
  int force_width;
  int busy_cycles;
  bit sel_seen;

  msp430_clock_switch_ctrl dut (
    .clk_in0_inv   (clk_in0_inv),
    .reset         (reset),
    .req_sel       (req_sel),
    .osc1_ready    (osc1_ready),
    .clk1_toggle   (clk1_toggle),
    .mux_ack       (mux_ack),
    .fail_clr      (fail_clr),
    .selection     (selection),
    .mux_force_rst (mux_force_rst),
    .sel_status    (sel_status),
    .busy          (busy),
    .fail_irq      (fail_irq),
    .fail_flag     (fail_flag)
  );

  initial begin
    clk_in0_inv = 1'b0;
    forever #5 clk_in0_inv = ~clk_in0_inv;
  end

  // clk1_toggle flips on every falling edge while enabled, far from the sampling point.
  initial begin
    clk1_toggle = 1'b0;
    forever begin
      @(negedge clk_in0_inv);
      if (tog_en) clk1_toggle = ~clk1_toggle;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 2 ns after the rising edge.
  task automatic step();
    @(posedge clk_in0_inv);
    #2;
    if (fail_irq === 1'b1) irq_cnt++;
  endtask

  task automatic wait_selection(input string tag);
    for (int i = 0; i < 12 && selection !== 1'b1; i++) step();
    check(tag, selection, 1);
  endtask

  task automatic go_sel1(input string tag);
    req_sel = 1'b1;
    wait_selection({tag, "_sel"});
    mux_ack = 1'b1;
    for (int i = 0; i < 12 && sel_status !== 1'b1; i++) step();
    check({tag, "_status"}, sel_status, 1);
  endtask

  task automatic clear_fail(input string tag);
    fail_clr = 1'b1;
    step();
    fail_clr = 1'b0;
    check(tag, fail_flag, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; irq_cnt = 0;
    reset = 1'b1; req_sel = 1'b0; osc1_ready = 1'b1; mux_ack = 1'b0;
    fail_clr = 1'b0; tog_en = 1'b1;

    // Reset values
    repeat (3) @(posedge clk_in0_inv);
    #2;
    check("rst_outputs", {selection, mux_force_rst, sel_status, busy, fail_irq, fail_flag}, 6'b0);
    #4 reset = 1'b0;
    step(); step();
    check("idle_outputs", {selection, mux_force_rst, sel_status, busy, fail_irq, fail_flag}, 6'b0);

    // 1: switch to clk_in1 with a ready, toggling oscillator
    irq_base = irq_cnt;
    req_sel = 1'b1;
    step();
    check("t1_busy_wait", busy, 1);
    check("t1_sel_early", selection, 0);
    wait_selection("t1_sel_rise");
    check("t1_busy_sw", busy, 1);
    // 2 synchroniser cycles, then SEL1 registered on the third edge
    mux_ack = 1'b1;
    step(); step();
    check("t1_status_pre", sel_status, 0);
    step();
    check("t1_status", sel_status, 1);
    check("t1_busy_done", busy, 0);

    // 4: return to clk_in0
    repeat (5) step();
    check("t4_hold_sel1", sel_status, 1);
    req_sel = 1'b0;
    step();
    check("t4_sel_drop", selection, 0);
    check("t4_status_drop", sel_status, 0);
    check("t4_busy", busy, 1);
    mux_ack = 1'b0;
    step(); step();
    check("t4_busy_pre", busy, 1);
    step();
    check("t4_idle", busy, 0);
    check("t4_no_irq", irq_cnt - irq_base, 0);

    // 3: clk_in1 activity lost in SEL1; last toggle lands just before the next edge.
    // 2 sync + 1 edge-detect + 16 window cycles -> fail registered on the 19th step.
    go_sel1("t3_enter");
    irq_base = irq_cnt;
    tog_en = 1'b0;
    repeat (18) step();
    check("t3_no_fail_yet", fail_irq, 0);
    check("t3_sel_held", selection, 1);
    step();
    check("t3_fail_irq", fail_irq, 1);
    check("t3_sel_drop", selection, 0);
    check("t3_fail_flag", fail_flag, 1);
    // mux_ack still 1: SW_TO0 times out after 32 counts, then FORCE for 4 cycles
    first_force = -1;
    force_width = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (mux_force_rst === 1'b1) begin
        if (first_force < 0) first_force = i;
        force_width++;
      end
    end
    check("t3_force_start", first_force, 33);
    check("t3_force_width", force_width, 4);
    check("t3_idle_status", sel_status, 0);
    check("t3_idle_busy", busy, 0);
    check("t3_one_irq", irq_cnt - irq_base, 1);
    tog_en = 1'b1;
    mux_ack = 1'b0;
    req_sel = 1'b0;
    clear_fail("t3_clear");

    // 2: oscillator never ready; WAIT_OSC lasts OSC_TIMEOUT+1 = 201 cycles
    osc1_ready = 1'b0;
    repeat (3) step();
    req_sel = 1'b1;
    step();
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    sel_seen = 1'b0;
    while (busy === 1'b1 && busy_cycles < 400) begin
      step();
      if (selection === 1'b1) sel_seen = 1'b1;
      if (busy === 1'b1) busy_cycles++;
    end
    check("t2_wait_len", busy_cycles, 201);
    check("t2_fail_irq", fail_irq, 1);
    check("t2_fail_flag", fail_flag, 1);
    check("t2_no_sel", sel_seen, 0);
    step();
    check("t2_irq_pulse", fail_irq, 0);
    repeat (5) step();
    check("t2_req_ignored", busy, 0);
    req_sel = 1'b0;
    osc1_ready = 1'b1;
    clear_fail("t2_clear");

    // 5: fail_clr coincident with an ack timeout in SW_TO1
    repeat (3) step();
    req_sel = 1'b1;
    wait_selection("t5_sel");
    repeat (32) step();
    check("t5_pre_timeout", fail_irq, 0);
    fail_clr = 1'b1;
    step();
    fail_clr = 1'b0;
    check("t5_fail_irq", fail_irq, 1);
    check("t5_set_wins", fail_flag, 1);
    check("t5_sel_drop", selection, 0);
    step(); step();
    check("t5_idle", busy, 0);
    req_sel = 1'b0;
    clear_fail("t5_clear");
    go_sel1("t5_reenabled");
    req_sel = 1'b0;
    step();
    mux_ack = 1'b0;
    repeat (4) step();
    check("t5_back_idle", busy, 0);

    // 6: asynchronous reset in SW_TO1
    req_sel = 1'b1;
    wait_selection("t6_sel");
    check("t6_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_async_rst", {selection, mux_force_rst, sel_status, busy, fail_irq, fail_flag}, 6'b0);
    req_sel = 1'b0;
    #3 reset = 1'b0;
    step(); step();
    check("t6_after_rst", {selection, mux_force_rst, sel_status, busy, fail_irq, fail_flag}, 6'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
